// File: rtl/lsu_axi_master_if.sv
// Core-side request/response channel plus the single-beat AXI4 master port of the LSU.
// The master modport is the LSU view; slave is the core-plus-memory view used by the bench.
interface lsu_axi_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        io_master_awready;
  logic        io_master_awvalid;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;

  logic        io_master_wready;
  logic        io_master_wvalid;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_wlast;

  logic        io_master_bready;
  logic        io_master_bvalid;
  logic [1:0]  io_master_bresp;
  logic [3:0]  io_master_bid;

  logic        io_master_arready;
  logic        io_master_arvalid;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;

  logic        io_master_rready;
  logic        io_master_rvalid;
  logic [1:0]  io_master_rresp;
  logic [31:0] io_master_rdata;
  logic        io_master_rlast;
  logic [3:0]  io_master_rid;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_mask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    input  io_master_awready,
    output io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
           io_master_awsize, io_master_awburst,
    input  io_master_wready,
    output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    input  io_master_bvalid, io_master_bresp, io_master_bid,
    output io_master_bready,
    input  io_master_arready,
    output io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
           io_master_arsize, io_master_arburst,
    input  io_master_rvalid, io_master_rresp, io_master_rdata, io_master_rlast, io_master_rid,
    output io_master_rready
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    output io_master_awready,
    input  io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
           io_master_awsize, io_master_awburst,
    output io_master_wready,
    input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    output io_master_bvalid, io_master_bresp, io_master_bid,
    input  io_master_bready,
    output io_master_arready,
    input  io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
           io_master_arsize, io_master_arburst,
    output io_master_rvalid, io_master_rresp, io_master_rdata, io_master_rlast, io_master_rid,
    input  io_master_rready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Load/store unit: one request at a time, issued as a single-beat AXI4 transaction
// with lane-aligned strobe/data, answered with lane-shifted load data or store completion.
module lsu_axi_master #(
  parameter logic [3:0] AXI_ID    = 4'h1,
  parameter bit         CHK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_axi_master_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP} state_t;

  state_t      state, state_nxt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        aw_done, w_done;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        aw_valid, w_valid, ar_valid;
  logic        accept, misaligned;
  logic [1:0]  lane;
  logic [2:0]  size;

  assign lane = addr_q[1:0];

  // Alignment is judged on the incoming request so a bad access never reaches the bus.
  assign misaligned = ((bus.req_mask == 4'b0011) && bus.req_addr[0]) ||
                      ((bus.req_mask == 4'b1111) && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    unique case (mask_q)
      4'b0001: size = 3'd0;
      4'b0011: size = 3'd1;
      default: size = 3'd2;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt            = state;
    accept               = 1'b0;
    aw_valid             = 1'b0;
    w_valid              = 1'b0;
    ar_valid             = 1'b0;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.io_master_bready = 1'b0;
    bus.io_master_rready = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (CHK_ALIGN && misaligned) state_nxt = S_RESP;
          else if (bus.req_wen)        state_nxt = S_WR;
          else                         state_nxt = S_AR;
        end
      end
      S_AR: begin
        ar_valid = 1'b1;
        if (bus.io_master_arready) state_nxt = S_R;
      end
      S_R: begin
        bus.io_master_rready = 1'b1;
        if (bus.io_master_rvalid) state_nxt = S_RESP;
      end
      S_WR: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        if ((aw_done || bus.io_master_awready) && (w_done || bus.io_master_wready))
          state_nxt = S_B;
      end
      S_B: begin
        bus.io_master_bready = 1'b1;
        if (bus.io_master_bvalid) state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= bus.req_wen;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        mask_q  <= bus.req_mask;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        rdata_q <= '0;
        err_q   <= CHK_ALIGN && misaligned;
      end
      if (aw_valid && bus.io_master_awready) aw_done <= 1'b1;
      if (w_valid && bus.io_master_wready)   w_done  <= 1'b1;
      if (state == S_R && bus.io_master_rvalid) begin
        rdata_q <= bus.io_master_rdata >> {lane, 3'b000};
        err_q   <= bus.io_master_rresp[1] || (bus.io_master_rid != AXI_ID);
      end
      if (state == S_B && bus.io_master_bvalid)
        err_q <= bus.io_master_bresp[1] || (bus.io_master_bid != AXI_ID);
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign bus.io_master_awvalid = aw_valid;
  assign bus.io_master_awaddr  = addr_q;
  assign bus.io_master_awid    = AXI_ID;
  assign bus.io_master_awlen   = 8'd0;
  assign bus.io_master_awsize  = size;
  assign bus.io_master_awburst = 2'b01;

  assign bus.io_master_wvalid  = w_valid;
  assign bus.io_master_wdata   = wdata_q << {lane, 3'b000};
  assign bus.io_master_wstrb   = mask_q << lane;
  assign bus.io_master_wlast   = w_valid;

  assign bus.io_master_arvalid = ar_valid;
  assign bus.io_master_araddr  = addr_q;
  assign bus.io_master_arid    = AXI_ID;
  assign bus.io_master_arlen   = 8'd0;
  assign bus.io_master_arsize  = size;
  assign bus.io_master_arburst = 2'b01;

  // Single-beat reads make rlast redundant; only the error bit of each resp is meaningful.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.io_master_rlast, bus.io_master_rresp[0],
                       bus.io_master_bresp[0], wen_q};

endmodule
